// File: rtl/regfile_mp.sv
// Purpose : multi-port register file (NUM_READ read ports, two prioritised write ports,
//           debug read port) with a hardware zeroing sweep after reset or on clr.
// Latency : 1 cycle on all reads; same-edge writes bypass into the registered read data.
// Backpressure: none; busy high during the sweep, while writes are dropped and reads return 0.
// Ports:
//   clk, rst (async, active-high), clr (one-cycle clear request), busy (sweep running)
//   raddr/rdata : packed read ports, port i at [i*ADDR_WIDTH +: ADDR_WIDTH] / [i*DATA_WIDTH +: DATA_WIDTH]
//   we0/waddr0/wdata0, we1/waddr1/wdata1 : write ports, port 1 wins on address collision
//   debug_addr/debug_data : extra registered read port for the display
module regfile_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clr,
   output logic                             busy,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr,
   output logic [NUM_READ*DATA_WIDTH-1:0]   rdata,
   input  logic                             we0,
   input  logic [ADDR_WIDTH-1:0]            waddr0,
   input  logic [DATA_WIDTH-1:0]            wdata0,
   input  logic                             we1,
   input  logic [ADDR_WIDTH-1:0]            waddr1,
   input  logic [DATA_WIDTH-1:0]            wdata1,
   input  logic [ADDR_WIDTH-1:0]            debug_addr,
   output logic [DATA_WIDTH-1:0]            debug_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   idx, idx_nxt;

   // Entry 0 has no storage; it reads as zero.
   logic [DATA_WIDTH-1:0]   mem [1:DEPTH-1];

   logic                    wr_en;
   logic                    rd_zero;
   logic                    wr0_ok;
   logic                    wr1_ok;

   // A clr seen in IDLE drops that edge's writes and zeroes the reads so the
   // outputs are already quiet on the first busy cycle.
   assign busy    = (state == CLEAR);
   assign wr_en   = (state == IDLE) && !clr;
   assign rd_zero = (state == CLEAR) || clr;
   assign wr0_ok  = wr_en && we0 && (waddr0 != '0);
   assign wr1_ok  = wr_en && we1 && (waddr1 != '0);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         CLEAR: begin
            if (clr) begin
               idx_nxt = FIRST;
            end else if (idx == LAST) begin
               state_nxt = IDLE;
            end else begin
               idx_nxt = idx + FIRST;
            end
         end
         IDLE: begin
            if (clr) begin
               state_nxt = CLEAR;
               idx_nxt   = FIRST;
            end
         end
         default: begin
            state_nxt = CLEAR;
            idx_nxt   = FIRST;
         end
      endcase
   end

   // Write-first read: port 1 has priority over port 0, then the array.
   function automatic logic [DATA_WIDTH-1:0] read_val(input logic [ADDR_WIDTH-1:0] a);
      logic [DATA_WIDTH-1:0] v;
      v = '0;
      if (rd_zero || (a == '0)) begin
         v = '0;
      end else if (wr1_ok && (waddr1 == a)) begin
         v = wdata1;
      end else if (wr0_ok && (waddr0 == a)) begin
         v = wdata0;
      end else begin
         v = mem[a];
      end
      return v;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= CLEAR;
         idx        <= FIRST;
         rdata      <= '0;
         debug_data <= '0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         for (int i = 0; i < NUM_READ; i++) begin
            rdata[i*DATA_WIDTH +: DATA_WIDTH] <= read_val(raddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
         end
         debug_data <= read_val(debug_addr);
      end
   end

   // Array is not reset; the sweep zeroes it one entry per edge.
   // Port 1 is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[idx] <= '0;
      end else begin
         if (wr0_ok) begin
            mem[waddr0] <= wdata0;
         end
         if (wr1_ok) begin
            mem[waddr1] <= wdata1;
         end
      end
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined MIPS CPU, replacing the fixed 32x32, two-read, one-write register file. Adds a configurable number of read ports, two prioritised write ports, write-first bypass on registered reads, and a hardware clear sweep that zeroes the array after reset or on request. It sits in the ID stage; the debug read port feeds the on-board display.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries, entry 0 hard-wired to zero
- NUM_READ, 2, number of read ports (1..4)

- clk  in  1  main clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear request, one-cycle pulse
- busy  out  1  clear sweep in progress
- raddr  in  NUM_READ*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NUM_READ*DATA_WIDTH  registered read data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- we0, waddr0 [ADDR_WIDTH], wdata0 [DATA_WIDTH]  in  write port 0
- we1, waddr1 [ADDR_WIDTH], wdata1 [DATA_WIDTH]  in  write port 1 (higher priority)
- debug_addr  in  ADDR_WIDTH  debug read address
- debug_data  out  DATA_WIDTH  registered debug read data

## Operation
- Storage covers entries 1..DEPTH-1. Reads of address 0 always return 0. Writes to address 0 are discarded.
- FSM has two states, CLEAR and IDLE. A sweep index idx is ADDR_WIDTH bits wide.
- rst asserted: state=CLEAR, idx=1, busy=1, all rdata=0, debug_data=0. Array contents are not reset directly; the sweep zeroes them.
- CLEAR: each rising edge writes mem[idx]<=0 and increments idx. On the edge where idx==DEPTH-1, the FSM moves to IDLE and busy drops. Write ports are ignored. rdata and debug_data register 0.
- clr=1 in IDLE: the next edge enters CLEAR with idx=1, and that edge's write-port activity is dropped. clr=1 during CLEAR restarts the sweep at idx=1.
- IDLE write: weN && waddrN!=0 writes wdataN. If both ports target the same nonzero address, port 1's data is stored.
- IDLE read: each port registers mem[raddr_i] at the rising edge.
- Bypass (write-first): if a same-edge write targets raddr_i (nonzero), rdata_i takes that write data. When both ports collide on that address, port 1's data is used.
- The debug port follows the same read and bypass rules.

## Timing
- Read latency is 1 cycle: an address presented before edge k appears on rdata after edge k.
- A write issued at edge k is visible through bypass on the same edge, and from the array from edge k+1 on.
- After rst is released, busy stays high for DEPTH-1 rising edges (31 by default). busy is low after the 31st edge, and the first write is accepted at the 32nd.
- clr sampled in IDLE: busy goes high after that edge and stays high for DEPTH-1 edges.
- rst asserted mid-sweep or mid-write: takes effect immediately and the sweep restarts from idx=1. A write on the release edge is dropped.
- With DEPTH-1 edges at ADDR_WIDTH=1, the sweep lasts exactly one edge.

## Test plan
- Reset sweep: assert rst, release, write 0xDEADBEEF to r5 after busy falls, read r5 -> busy high for exactly 31 edges, every entry reads 0 after the sweep, then r5 reads 0xDEADBEEF one cycle after its address is applied.
- Dual write collision: we0=we1=1, waddr0=waddr1=7, wdata0=0x11, wdata1=0x22 -> r7=0x22. Same-edge read of r7 returns 0x22 via bypass.
- Zero register: write 0xFFFFFFFF to r0 on both ports -> every read port and debug_data return 0 for address 0.
- Bypass on all ports: NUM_READ=3, all raddr=9, write 0x1234 to r9 on port 0 -> all three rdata return 0x1234 on the same edge.
- Clear mid-run: fill r1..r31 with their index, pulse clr, write r3 during busy -> write dropped, busy high 31 edges, all entries 0, reads during busy return 0.
- Async reset mid-sweep: assert rst between edges at idx=15 -> outputs go 0 immediately, the sweep restarts at idx=1, busy high 31 edges after release.
